int_vector_mac_sequencer: RTL and testbench
===========================================

# int_vector_mac_sequencer

Control stage directly upstream of `int_vector_mac`. It accepts a dot-product length command and a stream of operand-vector beats over valid/ready, drives the MAC's operand vectors and synchronous clear, and captures the final `mac_o` value. It then returns that value over a valid/ready result channel. One command yields exactly one result; the MAC is instantiated beside this block, not inside it.

## Interface
Parameters:
- `DataWidth`, 8, element width of each operand lane (matches MAC).
- `Size`, 16, lanes per operand vector (matches MAC).
- `AccumulatorWidth`, 32, width of the MAC accumulator and the result.
- `LengthWidth`, 16, width of the beat-count command.

Ports:
- `clock`  in  1  sole clock; all logic on rising edge.
- `reset_ni`  in  1  asynchronous, active-low reset.
- `len_i`  in  LengthWidth  number of beats K in the next dot product.
- `len_valid_i` / `len_ready_o`  in/out  1  command handshake.
- `op0_vec_i`, `op1_vec_i`  in  Size×DataWidth  signed operand beat.
- `in_valid_i` / `in_ready_o`  in/out  1  beat handshake.
- `mac_op0_vec_o`, `mac_op1_vec_o`  out  Size×DataWidth  to MAC `op0_vec_i` / `op1_vec_i`.
- `mac_clear_o`  out  1  to MAC `reset_i` (synchronous active-high clear).
- `mac_i`  in  AccumulatorWidth  from MAC `mac_o`.
- `res_data_o`  out  AccumulatorWidth  signed dot-product result.
- `res_valid_o` / `res_ready_i`  out/in  1  result handshake.
- `busy_o`  out  1  high in any state other than SeqIdle.

## Operation
- Four-state FSM:
  - SeqIdle: `len_ready_o`=1, `mac_clear_o`=1.
  - SeqAccum: `in_ready_o`=1, `mac_clear_o`=0.
  - SeqCapture: one cycle; `mac_clear_o`=0.
  - SeqResult: `res_valid_o`=1, `mac_clear_o`=1.
- SeqIdle → SeqAccum on a `len` handshake with K≥1. The remaining-beat counter loads K.
- SeqIdle → SeqCapture on a `len` handshake with K=0. The MAC is already cleared, so the result is 0.
- SeqAccum: each `in` handshake decrements the counter. On the beat that makes the counter reach 0, the FSM moves to SeqCapture.
- MAC operand outputs are combinational: the input vectors when `in_valid_i && in_ready_o`, otherwise all-zero. The MAC therefore holds its value on stall cycles.
- SeqCapture: `res_data_o` register ← `mac_i`. Then move to SeqResult.
- SeqResult: hold `res_data_o` stable until `res_ready_i`, then return to SeqIdle. The MAC stays cleared in SeqResult, so the next command starts from 0.
- Arithmetic is owned by the MAC. The result wraps modulo 2^AccumulatorWidth, with no saturation or overflow flag.
- `len_i` and the operand inputs are ignored outside their ready states. `res_ready_i` is ignored when `res_valid_o`=0.

## Timing
- Reset (asynchronous assert, synchronous deassert outside this block) drives:
  - state SeqIdle and counter 0;
  - `res_data_o`=0, `res_valid_o`=0, `busy_o`=0;
  - `mac_clear_o`=1 and `mac_op*_vec_o`=0.
- Ready signals are decoded from state, so after reset deassertion `len_ready_o`=1 and `in_ready_o`=0.
- Latency: if the final beat handshakes in cycle n, `res_valid_o` rises in cycle n+2.
- A K=0 command accepted in cycle n gives `res_valid_o` in cycle n+2 with value 0.
- Minimum spacing: results are spaced at least K+3 cycles apart.
- No combinational path from any `*_valid_i` or `res_ready_i` to any ready output.
- Back-to-back: a `res` handshake in cycle m allows a `len` handshake in cycle m+1.
- Reset mid-operation: partial sums and any pending result are discarded. No result is emitted for the aborted command.
- Counter width is LengthWidth. K = 2^LengthWidth−1 is legal and must not wrap.

## Structure
- Package `int_vector_mac_pkg` holds:
  - `typedef enum logic [1:0] seq_state_e {SeqIdle, SeqAccum, SeqCapture, SeqResult}`;
  - the derived constant `MultDataWidth`.
- One sub-module, `beat_counter`: loadable down-counter with `load_i`, `dec_i`, `value_i`, and `zero_o`, parameterised by LengthWidth.
- Result register and FSM live in the top.

## Test plan
- Single beat: K=1, op0 all 3, op1 all 2, Size=16 → `res_data_o`=96, valid two cycles after the beat.
- Stalled stream: K=4, `in_valid_i` toggling every other cycle, lanes op0=i, op1=1 → result 4×120=480. `mac_op*` must be zero on stall cycles.
- Negative values and back-pressure: K=2, op0 all −128, op1 all 127; hold `res_ready_i` low 5 cycles → result −520192, held stable until ready.
- K=0 command → `res_data_o`=0 in cycle n+2; no `in_ready_o` pulse.
- Wrap: AccumulatorWidth=16, K=3, op0 all 127, op1 all 127 → 774192 mod 2^16, sign-interpreted = −12240.
- Reset asserted mid-SeqAccum after 2 of 5 beats → all outputs at reset values immediately. A following K=1 command (op0 all 1, op1 all 1) returns 16, with no residue from the aborted command.

Source files
------------

// File: rtl/int_vector_mac_pkg.sv
// Shared types and constants for the int_vector_mac control path.
//   seq_state_e   : sequencer FSM states
//   MultDataWidth : width of one signed lane product for the default lane width
package int_vector_mac_pkg;

    typedef enum logic [1:0] {
        SeqIdle,
        SeqAccum,
        SeqCapture,
        SeqResult
    } seq_state_e;

    localparam int DefaultDataWidth = 8;
    localparam int MultDataWidth    = 2 * DefaultDataWidth;

endpackage

// File: rtl/int_vector_mac_sequencer_beat_counter.sv
// Loadable down-counter tracking the operand beats still owed for the
// current dot product.
//   clock, reset_ni : clock, asynchronous active-low reset
//   load_i, value_i : load the beat count K
//   dec_i           : one beat accepted
//   count_o         : beats remaining
//   zero_o          : no beats remaining
module beat_counter #(
    parameter int LengthWidth = 16
) (
    input  logic                   clock,
    input  logic                   reset_ni,
    input  logic                   load_i,
    input  logic                   dec_i,
    input  logic [LengthWidth-1:0] value_i,
    output logic [LengthWidth-1:0] count_o,
    output logic                   zero_o
);

    logic [LengthWidth-1:0] count_q;

    // Saturates at zero so a stray decrement can never wrap to the maximum.
    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= value_i;
        end else if (dec_i && (count_q != '0)) begin
            count_q <= count_q - LengthWidth'(1);
        end
    end

    assign count_o = count_q;
    assign zero_o  = (count_q == '0);

endmodule

// File: rtl/int_vector_mac_sequencer.sv
// Control stage in front of int_vector_mac: takes a beat-count command and a
// stream of operand beats, steers them into the MAC, captures the final
// accumulator and returns it over a valid/ready result channel.
//   clock, reset_ni                  : clock, asynchronous active-low reset
//   len_i, len_valid_i, len_ready_o  : dot-product length command
//   op0_vec_i, op1_vec_i, in_valid_i, in_ready_o : operand beats
//   mac_op0_vec_o, mac_op1_vec_o     : operands to the MAC (zero when idle)
//   mac_clear_o                      : synchronous clear to the MAC
//   mac_i                            : MAC accumulator output
//   res_data_o, res_valid_o, res_ready_i : result channel
//   busy_o                           : a command is in flight
module int_vector_mac_sequencer
    import int_vector_mac_pkg::*;
#(
    parameter int DataWidth        = 8,
    parameter int Size             = 16,
    parameter int AccumulatorWidth = 32,
    parameter int LengthWidth      = 16
) (
    input  logic                               clock,
    input  logic                               reset_ni,
    input  logic [LengthWidth-1:0]             len_i,
    input  logic                               len_valid_i,
    output logic                               len_ready_o,
    input  logic [Size*DataWidth-1:0]          op0_vec_i,
    input  logic [Size*DataWidth-1:0]          op1_vec_i,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    output logic [Size*DataWidth-1:0]          mac_op0_vec_o,
    output logic [Size*DataWidth-1:0]          mac_op1_vec_o,
    output logic                               mac_clear_o,
    input  logic [AccumulatorWidth-1:0]        mac_i,
    output logic signed [AccumulatorWidth-1:0] res_data_o,
    output logic                               res_valid_o,
    input  logic                               res_ready_i,
    output logic                               busy_o
);

    seq_state_e             state_q, state_d;
    logic                   len_fire, in_fire, res_fire;
    logic                   len_zero;
    logic [LengthWidth-1:0] beats_left;
    logic                   beats_zero;
    logic                   last_beat;

    logic signed [AccumulatorWidth-1:0] res_data_p1;

    assign len_fire  = len_valid_i && len_ready_o;
    assign in_fire   = in_valid_i && in_ready_o;
    assign res_fire  = res_valid_o && res_ready_i;
    assign len_zero  = (len_i == '0);
    assign last_beat = in_fire && (beats_left == LengthWidth'(1));

    beat_counter #(
        .LengthWidth(LengthWidth)
    ) u_beat_counter (
        .clock   (clock),
        .reset_ni(reset_ni),
        .load_i  (len_fire),
        .dec_i   (in_fire),
        .value_i (len_i),
        .count_o (beats_left),
        .zero_o  (beats_zero)
    );

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= SeqIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            SeqIdle: begin
                if (len_fire) begin
                    state_d = len_zero ? SeqCapture : SeqAccum;
                end
            end
            // beats_zero in SeqAccum is unreachable in normal flow; leaving
            // through capture keeps the FSM from stalling forever if it occurs.
            SeqAccum: begin
                if (last_beat || beats_zero) begin
                    state_d = SeqCapture;
                end
            end
            SeqCapture: state_d = SeqResult;
            SeqResult: begin
                if (res_fire) begin
                    state_d = SeqIdle;
                end
            end
            default: state_d = SeqIdle;
        endcase
    end

    // Handshake outputs come from state alone, so no valid-to-ready path exists.
    always_comb begin
        len_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        res_valid_o = 1'b0;
        mac_clear_o = 1'b1;
        busy_o      = 1'b1;
        unique case (state_q)
            SeqIdle: begin
                len_ready_o = 1'b1;
                busy_o      = 1'b0;
            end
            SeqAccum: begin
                in_ready_o  = 1'b1;
                mac_clear_o = 1'b0;
            end
            SeqCapture: mac_clear_o = 1'b0;
            SeqResult:  res_valid_o = 1'b1;
            default: ;
        endcase
    end

    // Zero operands on non-accepted cycles make the MAC hold its sum.
    assign mac_op0_vec_o = in_fire ? op0_vec_i : '0;
    assign mac_op1_vec_o = in_fire ? op1_vec_i : '0;

    // ---- capture stage: MAC output settles one cycle after the last beat ----
    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            res_data_p1 <= '0;
        end else if (state_q == SeqCapture) begin
            res_data_p1 <= $signed(mac_i);
        end
    end

    assign res_data_o = res_data_p1;

endmodule

// File: tb/tb_int_vector_mac_sequencer.sv
module tb_int_vector_mac_sequencer;

    localparam int DW = 8;
    localparam int SZ = 16;
    localparam int LW = 16;
    localparam int VW = SZ * DW;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          reset_ni;
    logic [LW-1:0] len_i;
    logic          len_valid_i;
    logic [VW-1:0] op0_vec_i, op1_vec_i;
    logic          in_valid_i;
    logic          res_ready_i;

    // 32-bit accumulator instance
    logic                len_ready_a, in_ready_a, clr_a, res_valid_a, busy_a;
    logic [VW-1:0]       mop0_a, mop1_a;
    logic signed [31:0]  res_a;
    logic signed [31:0]  acc_a = '0;

    // 16-bit accumulator instance, same stimulus, exercises wrap-around
    logic                len_ready_b, in_ready_b, clr_b, res_valid_b, busy_b;
    logic [VW-1:0]       mop0_b, mop1_b;
    logic signed [15:0]  res_b;
    logic signed [15:0]  acc_b = '0;

    int n_checks = 0;
    int n_pass   = 0;

    int_vector_mac_sequencer #(
        .DataWidth(DW), .Size(SZ), .AccumulatorWidth(32), .LengthWidth(LW)
    ) dut_a (
        .clock(clock), .reset_ni(reset_ni),
        .len_i(len_i), .len_valid_i(len_valid_i), .len_ready_o(len_ready_a),
        .op0_vec_i(op0_vec_i), .op1_vec_i(op1_vec_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_a),
        .mac_op0_vec_o(mop0_a), .mac_op1_vec_o(mop1_a), .mac_clear_o(clr_a),
        .mac_i(acc_a),
        .res_data_o(res_a), .res_valid_o(res_valid_a), .res_ready_i(res_ready_i),
        .busy_o(busy_a)
    );

    int_vector_mac_sequencer #(
        .DataWidth(DW), .Size(SZ), .AccumulatorWidth(16), .LengthWidth(LW)
    ) dut_b (
        .clock(clock), .reset_ni(reset_ni),
        .len_i(len_i), .len_valid_i(len_valid_i), .len_ready_o(len_ready_b),
        .op0_vec_i(op0_vec_i), .op1_vec_i(op1_vec_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_b),
        .mac_op0_vec_o(mop0_b), .mac_op1_vec_o(mop1_b), .mac_clear_o(clr_b),
        .mac_i(acc_b),
        .res_data_o(res_b), .res_valid_o(res_valid_b), .res_ready_i(res_ready_i),
        .busy_o(busy_b)
    );

    function automatic longint dot(input logic [VW-1:0] a, input logic [VW-1:0] b);
        longint s = 0;
        for (int i = 0; i < SZ; i++) begin
            s += longint'($signed(a[i*DW +: DW])) * longint'($signed(b[i*DW +: DW]));
        end
        return s;
    endfunction

    // Behavioural stand-in for the MAC sitting next to each sequencer.
    always @(posedge clock) begin
        acc_a <= clr_a ? 32'sd0 : acc_a + 32'(dot(mop0_a, mop1_a));
        acc_b <= clr_b ? 16'sd0 : acc_b + 16'(dot(mop0_b, mop1_b));
    end

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // mode 0: random lanes, 1: constant lanes a/b, 2: op0 lane i = i, op1 = 1
    task automatic make_beat(input int mode, input int a, input int b,
                             output logic [VW-1:0] v0, output logic [VW-1:0] v1);
        for (int i = 0; i < SZ; i++) begin
            case (mode)
                1:       begin v0[i*DW +: DW] = DW'(a); v1[i*DW +: DW] = DW'(b); end
                2:       begin v0[i*DW +: DW] = DW'(i); v1[i*DW +: DW] = DW'(1); end
                default: begin v0[i*DW +: DW] = DW'($urandom); v1[i*DW +: DW] = DW'($urandom); end
            endcase
        end
    endtask

    // stall 0: none, 1: every other cycle idle, 2: random idles
    task automatic run_cmd(input int k, input int mode, input int a, input int b,
                           input int stall, input int hold);
        longint          sum = 0;
        logic [63:0]     su;
        int              sent = 0;
        int              guard = 0;
        bit              stl;
        logic [VW-1:0]   v0, v1;
        longint          held;

        len_i = LW'(k);
        len_valid_i = 1'b1;
        #1;
        check_eq("len_ready_idle", len_ready_a, 1);
        check_eq("busy_idle", busy_a, 0);
        @(posedge clock); #1;
        len_valid_i = 1'b0;
        len_i = LW'($urandom);

        while (sent < k && guard < 4 * k + 20) begin
            stl = (stall == 1) ? (guard % 2 == 1) :
                  (stall == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
            make_beat(mode, a, b, v0, v1);
            in_valid_i = !stl;
            op0_vec_i = v0;
            op1_vec_i = v1;
            #1;
            if (k < 64) begin
                check_eq("in_ready_accum", in_ready_a, 1);
                check_eq("clear_accum", clr_a, 0);
                check_eq("res_valid_accum", res_valid_a, 0);
                if (stl) check_eq("mac_op_stall_zero", (mop0_a == '0) && (mop1_a == '0), 1);
                else     check_eq("mac_op_pass", (mop0_a == v0) && (mop1_a == v1), 1);
            end
            @(posedge clock); #1;
            if (!stl) begin
                sum += dot(v0, v1);
                sent++;
            end
            guard++;
        end
        if (sent < k) check_eq("beat_timeout", sent, k);
        in_valid_i = 1'b0;

        // cycle n+1 after final beat / zero-length command: still capturing
        check_eq("res_valid_n1", res_valid_a, 0);
        check_eq("in_ready_capture", in_ready_a, 0);
        @(posedge clock); #1;
        su = sum;
        check_eq("res_valid_n2", res_valid_a, 1);
        check_eq("res_valid_n2_w16", res_valid_b, 1);
        check_eq("res_data_w32", res_a, longint'($signed(su[31:0])));
        check_eq("res_data_w16", res_b, longint'($signed(su[15:0])));
        check_eq("in_ready_result", in_ready_a, 0);

        held = res_a;
        for (int h = 0; h < hold; h++) begin
            res_ready_i = 1'b0;
            @(posedge clock); #1;
            check_eq("res_valid_hold", res_valid_a, 1);
            check_eq("res_data_hold", res_a, held);
        end
        res_ready_i = 1'b1;
        @(posedge clock); #1;
        res_ready_i = 1'b0;
        check_eq("res_valid_after_hs", res_valid_a, 0);
        check_eq("len_ready_after_hs", len_ready_a, 1);
        check_eq("busy_after_hs", busy_a, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"}, busy_a, 0);
        check_eq({tag, "_res_valid"}, res_valid_a, 0);
        check_eq({tag, "_res_data"}, res_a, 0);
        check_eq({tag, "_len_ready"}, len_ready_a, 1);
        check_eq({tag, "_in_ready"}, in_ready_a, 0);
        check_eq({tag, "_mac_clear"}, clr_a, 1);
        check_eq({tag, "_mac_op_zero"}, (mop0_a == '0) && (mop1_a == '0), 1);
    endtask

    initial begin
        logic [VW-1:0] v0, v1;
        reset_ni    = 1'b0;
        len_i       = '0;
        len_valid_i = 1'b0;
        op0_vec_i   = '0;
        op1_vec_i   = '0;
        in_valid_i  = 1'b0;
        res_ready_i = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check_reset_outputs("reset");
        reset_ni = 1'b1;
        @(posedge clock); #1;
        check_reset_outputs("post_reset");

        run_cmd(1, 1, 3, 2, 0, 0);            // 96
        run_cmd(4, 2, 0, 0, 1, 1);            // 480 with alternating stalls
        run_cmd(2, 1, -128, 127, 0, 5);       // -520192 under back-pressure
        run_cmd(0, 0, 0, 0, 0, 2);            // zero-length command
        run_cmd(3, 1, 127, 127, 0, 0);        // 774192, wraps to -12240 at 16 bits
        for (int r = 0; r < 6; r++) begin
            run_cmd($urandom_range(1, 6), 0, 0, 0, 2, $urandom_range(0, 3));
        end

        // abort a K=5 command after two beats
        len_i = LW'(5);
        len_valid_i = 1'b1;
        @(posedge clock); #1;
        len_valid_i = 1'b0;
        for (int j = 0; j < 2; j++) begin
            make_beat(0, 0, 0, v0, v1);
            op0_vec_i = v0;
            op1_vec_i = v1;
            in_valid_i = 1'b1;
            @(posedge clock); #1;
        end
        reset_ni = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clock);
        #1;
        in_valid_i = 1'b0;
        reset_ni = 1'b1;
        @(posedge clock); #1;
        check_eq("no_result_after_abort", res_valid_a, 0);
        run_cmd(1, 1, 1, 1, 0, 0);            // 16, no residue

        run_cmd((1 << LW) - 1, 1, 1, 1, 0, 0); // maximum length, counter must not wrap

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
